// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file constants shared with RegFile and the dump FSM state type
package regfile_pkg;
  localparam int REG_DW = 8;
  localparam int REG_AW = 3;
  localparam int REG_COUNT = 8;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} dump_state_t;
endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks RegFile port A over an address range and streams each value out over valid/ready
module reg_dump
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] First,
  input  logic [AW-1:0] Last,
  output logic [AW-1:0] Ra,
  input  logic [DW-1:0] RdatA,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [DW-1:0] OutData,
  output logic [AW-1:0] OutAddr,
  output logic          Busy,
  output logic          Done
);
  dump_state_t state_q, state_d;
  logic [AW-1:0] last_q, last_d, ra_q, ra_d, addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ra_d    = ra_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        last_d  = Last;
        ra_d    = First;
        busy_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        data_d  = RdatA;
        addr_d  = ra_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (OutReady) begin
        valid_d = 1'b0;
        if (addr_q == last_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ra_d    = ra_q + 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      ra_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ra_q    <= ra_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign Ra       = ra_q;
  assign OutValid = valid_q;
  assign OutData  = data_q;
  assign OutAddr  = addr_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: register-file model plus a queue-based reference model checked every cycle
module tb_reg_dump;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic [2:0] First = '0, Last = '0, Ra, OutAddr;
  logic [7:0] RdatA, OutData;
  logic OutValid, Busy, Done;
  logic OutReady = 1'b1;
  logic wen = 1'b0;
  logic [2:0] wa = '0;
  logic [7:0] wd = '0;
  logic [7:0] core [8];
  int n_cmp = 0, n_fail = 0;
  bit chk_en = 0, rnd = 0;
  int stall_left = 0, stall_addr = 0;
  logic [10:0] acc [$];
  int q [$];
  logic [2:0] m_ra, m_addr;
  logic [7:0] m_data;
  logic m_valid, m_done, m_busy;

  always #5 Clk = ~Clk;

  reg_dump #(.DW(8), .AW(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .First(First), .Last(Last), .Ra(Ra),
    .RdatA(RdatA), .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutAddr(OutAddr), .Busy(Busy), .Done(Done)
  );

  always @(posedge Clk) if (wen) core[wa] <= wd;
  assign RdatA = core[Ra];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a dump is the list of addresses First..Last modulo 8; each word is fetched
  // one edge after the dump starts or after the previous word is accepted.
  always @(posedge Clk) begin
    if (Reset) begin
      q.delete();
      m_ra = 0; m_valid = 0; m_data = 0; m_addr = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (q.size() == 0) begin
        if (Start) begin
          for (int i = 0; i < ((int'(Last) - int'(First) + 8) % 8) + 1; i++)
            q.push_back((int'(First) + i) % 8);
          m_ra = First;
        end
      end else if (!m_valid) begin
        m_valid = 1;
        m_addr = 3'(q[0]);
        m_data = core[q[0]];
      end else if (OutReady) begin
        m_valid = 0;
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1;
        else m_ra = 3'(q[0]);
      end
    end
    m_busy = q.size() != 0;
  end

  always @(posedge Clk) if (!Reset && OutValid && OutReady) acc.push_back({OutAddr, OutData});

  always @(negedge Clk) begin
    if (rnd) OutReady = 1'($urandom_range(0, 1));
    else if (stall_left > 0 && OutValid && int'(OutAddr) == stall_addr) begin
      OutReady = 0;
      stall_left--;
    end else OutReady = 1;
  end

  always @(negedge Clk) if (chk_en) begin
    chk("ra", Ra, m_ra);
    chk("valid", OutValid, m_valid);
    chk("data", OutData, m_data);
    chk("addr", OutAddr, m_addr);
    chk("busy", Busy, m_busy);
    chk("done", Done, m_done);
  end

  task automatic run_dump(input string nm, input logic [2:0] f, input logic [2:0] l, input int n,
                          input logic [10:0] w [8], input int exp_edge, input int poke, input bit snap);
    int cyc;
    bit wrote;
    acc.delete();
    wrote = 0;
    First = f; Last = l; Start = 1;
    @(posedge Clk); @(negedge Clk);
    Start = 0;
    chk({nm, "_busy_edge0"}, Busy, 1);
    chk({nm, "_ra_edge0"}, Ra, f);
    for (cyc = 1; cyc <= 80; cyc++) begin
      @(posedge Clk); @(negedge Clk);
      wen = 0;
      if (Done) break;
      Start = (cyc == poke);
      if (cyc == poke) begin First = 4; Last = 5; end
      if (snap && !wrote && OutValid && OutAddr == 6) begin
        wen = 1; wa = 6; wd = 10; wrote = 1;
      end
    end
    Start = 0;
    chk({nm, "_done_edge"}, cyc, exp_edge);
    chk({nm, "_busy_at_done"}, Busy, 0);
    chk({nm, "_words"}, acc.size(), n);
    for (int i = 0; i < n && i < acc.size(); i++) chk($sformatf("%s_word%0d", nm, i), acc[i], w[i]);
    @(negedge Clk);
    chk({nm, "_done_pulse"}, Done, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      wen = 1; wa = 3'(i);
      wd = (i == 0) ? 8'd1 : (i == 1) ? 8'd31 : (i == 2) ? 8'd96 : (i == 7) ? 8'd5 : 8'd0;
    end
    @(negedge Clk);
    wen = 0;
    chk_en = 1;
    @(negedge Clk);
    Reset = 0;
    chk("rst_valid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_ra", Ra, 0);
    chk("rst_data", OutData, 0);
    @(negedge Clk);
    run_dump("full", 0, 7, 8, '{11'h001, 11'h11F, 11'h260, 11'h300, 11'h400, 11'h500, 11'h600, 11'h705}, 16, 0, 0);
    run_dump("wrap", 6, 1, 4, '{11'h600, 11'h705, 11'h001, 11'h11F, 0, 0, 0, 0}, 8, 0, 0);
    stall_addr = 2; stall_left = 3;
    run_dump("stall", 0, 7, 8, '{11'h001, 11'h11F, 11'h260, 11'h300, 11'h400, 11'h500, 11'h600, 11'h705}, 19, 0, 0);
    chk("stall_used", stall_left, 0);
    run_dump("single", 2, 2, 1, '{11'h260, 0, 0, 0, 0, 0, 0, 0}, 2, 0, 0);
    run_dump("poke", 0, 7, 8, '{11'h001, 11'h11F, 11'h260, 11'h300, 11'h400, 11'h500, 11'h600, 11'h705}, 16, 3, 0);
    First = 0; Last = 7; Start = 1;
    @(posedge Clk); @(negedge Clk);
    Start = 0;
    for (int i = 0; i < 40 && !(OutValid && OutAddr == 3); i++) @(negedge Clk);
    chk("abort_reach_word3", OutAddr, 3);
    Reset = 1;
    @(posedge Clk); @(negedge Clk);
    Reset = 0;
    chk("abort_valid", OutValid, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_ra", Ra, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("abort_no_done", Done, 0);
    end
    run_dump("after_rst", 0, 0, 1, '{11'h001, 0, 0, 0, 0, 0, 0, 0}, 2, 0, 0);
    run_dump("snap", 6, 7, 2, '{11'h600, 11'h705, 0, 0, 0, 0, 0, 0}, 4, 0, 1);
    chk("snap_written", core[6], 10);
    rnd = 1;
    repeat (2000) begin
      @(negedge Clk);
      Start = ($urandom_range(0, 3) == 0);
      First = 3'($urandom); Last = 3'($urandom);
      wen = ($urandom_range(0, 3) == 0); wa = 3'($urandom); wd = 8'($urandom);
      Reset = ($urandom_range(0, 199) == 0);
    end
    @(negedge Clk);
    Reset = 0; Start = 0; wen = 0;
    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
